// File: rtl/da_lut_loader.sv
// Collects 64 signed coefficients, then streams the 2048-entry distributed-arithmetic LUT
// to fir_filter in Gray-code order using a single add/subtract accumulator.
module da_lut_loader (
  input  logic        clk_slow,
  input  logic        reset,
  input  logic [15:0] coef_in,
  input  logic        coef_valid,
  output logic        coef_ready,
  input  logic        stall,
  output logic [19:0] CIN,
  output logic [10:0] CADDR,
  output logic        CLOAD,
  output logic        busy,
  output logic        done
);

  localparam int NCOEF = 64;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    GEN,
    DONE
  } state_t;

  state_t      state, state_next;
  logic [5:0]  cnt, cnt_next;
  logic [2:0]  grp, grp_next;
  logic [7:0]  n, n_next;
  logic [19:0] acc_next;
  logic [10:0] addr_next;
  logic        ready_next, busy_next, load_next, done_next;

  logic        handshake;
  logic        coef_we;
  logic [7:0]  n_inc;
  logic [7:0]  pattern_inc;
  logic [2:0]  flip_bit;
  logic [15:0] coef_sel;
  logic [19:0] coef_ext;

  logic [15:0] coef_mem [NCOEF];

  // Index of the single bit that changes between Gray codes of v-1 and v.
  function automatic logic [2:0] tzc8(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd7;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) r = 3'(i);
    end
    return r;
  endfunction

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latches).
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    grp_next    = grp;
    n_next      = n;
    acc_next    = CIN;
    addr_next   = CADDR;
    coef_we     = 1'b0;

    handshake   = coef_valid & coef_ready;
    n_inc       = n + 8'd1;
    pattern_inc = n_inc ^ (n_inc >> 1);
    flip_bit    = tzc8(n_inc);
    coef_sel    = coef_mem[{grp, flip_bit}];
    coef_ext    = {{4{coef_sel[15]}}, coef_sel};

    case (state)
      IDLE: begin
        cnt_next = '0;
        if (handshake) begin
          coef_we    = 1'b1;
          cnt_next   = 6'd1;
          state_next = COLLECT;
        end
      end

      COLLECT: begin
        if (handshake) begin
          coef_we  = 1'b1;
          cnt_next = cnt + 6'd1;
          if (cnt == 6'd63) begin
            state_next = GEN;
            grp_next   = '0;
            n_next     = '0;
            acc_next   = '0;
            addr_next  = '0;
          end
        end
      end

      GEN: begin
        if (!stall) begin
          if (n == 8'd255) begin
            n_next = '0;
            if (grp == 3'd7) begin
              state_next = DONE;
            end else begin
              grp_next  = grp + 3'd1;
              acc_next  = '0;
              addr_next = {grp + 3'd1, 8'd0};
            end
          end else begin
            // The bit that flips tells whether its coefficient enters or leaves the subset.
            n_next    = n_inc;
            addr_next = {grp, pattern_inc};
            acc_next  = pattern_inc[flip_bit] ? (CIN + coef_ext) : (CIN - coef_ext);
          end
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase

    ready_next = (state_next == IDLE) || (state_next == COLLECT);
    busy_next  = (state_next == COLLECT) || (state_next == GEN);
    load_next  = (state_next == GEN);
    done_next  = (state_next == DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_slow) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      grp        <= '0;
      n          <= '0;
      CIN        <= '0;
      CADDR      <= '0;
      CLOAD      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      coef_ready <= 1'b1;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      grp        <= grp_next;
      n          <= n_next;
      CIN        <= acc_next;
      CADDR      <= addr_next;
      CLOAD      <= load_next;
      busy       <= busy_next;
      done       <= done_next;
      coef_ready <= ready_next;
    end
  end

  // NOTE: the coefficient store has no reset; all 64 words are rewritten before GEN reads any.
  always_ff @(posedge clk_slow) begin
    if (coef_we && !reset) coef_mem[cnt] <= coef_in;
  end

endmodule

// File: doc/da_lut_loader.md
# da_lut_loader

Programs the fir_filter distributed-arithmetic LUT. It accepts 64 signed 16-bit coefficients on a valid/ready stream, then emits all 2048 partial-sum entries on the filter's CIN/CADDR/CLOAD port at one entry per clock. Each entry is the sum of the coefficients selected by its address bits. The block replaces software precomputation: it drives the LUT-writer side of the interface, and fir_filter is the reader.

## Interface
- NCOEF, 64: coefficients per load; fixed, 8 groups of 8.
- CW, 16: coefficient width, signed.
- clk_slow  in  1  sole clock; rising edge active.
- reset  in  1  synchronous, active-high.
- coef_in  in  16  signed coefficient; j-th accepted word is coef[j], j = 0..63.
- coef_valid  in  1  coef_in is valid.
- coef_ready  out  1  block can accept a coefficient.
- stall  in  1  freezes LUT output sequence while high (GEN only).
- CIN  out  20  signed LUT entry, two's complement.
- CADDR  out  11  LUT address; {group[2:0], pattern[7:0]}.
- CLOAD  out  1  high while CIN/CADDR carry a valid entry.
- busy  out  1  high in COLLECT or GEN.
- done  out  1  one-cycle pulse after the last entry is presented.

## Operation
- Entry value: LUT[256k + p] = sum over b = 0..7 with p[b] = 1 of coef[8k + b]; LUT[256k] = 0.
- Width: the range is -262144..262136, which fits in 19 bits signed. The accumulator is 20 bits and CIN is sign-extended. No saturation; no overflow is possible.
- States:
  - IDLE: coef_ready = 1, cnt = 0. A handshake (coef_valid & coef_ready) stores coef[0] and moves to COLLECT.
  - COLLECT: coef_ready = 1. Each handshake stores coef[cnt] and increments cnt. After the 64th handshake, go to GEN.
  - GEN: coef_ready = 0. Walk groups k = 0..7; within each group, walk n = 0..255 in Gray order, with pattern = n ^ (n >> 1).
    - At n = 0, the accumulator loads 0.
    - At step n, b = trailing-zero count of n. If pattern[b] becomes 1, add coef[8k + b]; otherwise subtract it.
    - One adder/subtractor is sufficient. No multiply is used.
    - After k = 7, n = 255 is presented and not stalled, go to DONE.
  - DONE: done = 1 and CLOAD = 0 for one cycle, then go to IDLE. The coefficient store is retained but is overwritten by the next load.
- Address order is not monotonic, and every address 0..2047 is written exactly once per load. The last address is 7*256 + 128 = 1920.
- stall = 1 in GEN: CIN, CADDR and CLOAD hold, and the sequence does not advance. stall is ignored in other states.
- coef_valid while coef_ready = 0 is ignored; no data is lost or stored.
- Reset in any state, including mid-GEN: next cycle is IDLE, CLOAD = 0, cnt = 0, and the partial LUT write is abandoned.

## Timing
- Reset values: coef_ready = 1 (IDLE), CIN = 0, CADDR = 0, CLOAD = 0, busy = 0, done = 0.
- All outputs are registered.
- The first entry (CADDR = 0, CIN = 0, CLOAD = 1) appears in the cycle after the 64th handshake edge.
- Unstalled GEN lasts exactly 2048 cycles with CLOAD continuously high. done follows in the next cycle.
- Each stalled cycle extends GEN by one cycle.
- Total from the first coefficient handshake to done with no stalls and back-to-back valid: 64 + 2048 + 1 cycles.
- The filter samples CIN/CADDR on any edge where CLOAD = 1 and the values are stable. Each entry is held at least one full clk_slow period.

## Test plan
- Single coefficient: coef[0] = 5, all others 0.
  - Every address with bit 0 set in group 0 carries 5; all other addresses carry 0.
  - Exactly 2048 CLOAD cycles, then a one-cycle done pulse.
- Extreme coefficients: coef = -32768 for all 64.
  - Each group's entry at pattern 255 is -262144 (CIN = 20'hC0000).
  - Each group's entry at pattern 1 is -32768 (CIN = 20'hF8000).
- Random coefficients compared against a software model of the sum-of-subset rule.
  - All 2048 addresses are written exactly once.
  - First CADDR = 0; last CADDR = 1920.
  - Every CIN matches the model.
- Stall behaviour: assert stall for 3 cycles at entry 100, and pulse coef_valid = 1 during GEN.
  - Outputs hold during the stall; GEN length is 2051 cycles.
  - coef_ready stays 0 and the extra coef_valid pulse is ignored.
- Gapped coefficient stream: coef_valid toggles each cycle.
  - 64 words are accepted over 127 cycles.
  - GEN starts one cycle after the 64th handshake.
- Reset mid-GEN: assert reset at entry 1000.
  - Next cycle: CLOAD = 0, busy = 0, coef_ready = 1.
  - A fresh 64-word load then completes correctly.
